// File: rtl/frame_capture_buffer.sv
// Double-buffered frame store: SOF-aligned capture into the back bank,
// 1-cycle reads from the front bank, with hold-deferred publication.
module frame_capture_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int IN_W       = 8,
  parameter int PIX_W      = 1,
  localparam int N  = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [IN_W-1:0]  x_data,
  input  logic             x_sof,
  input  logic             capture_trigger,
  input  logic             continuous,
  input  logic             capture_abort,
  input  logic             thresh_mode,
  input  logic [IN_W-1:0]  threshold,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_hold,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             capturing,
  output logic             capture_complete,
  output logic             frame_valid,
  output logic             front_bank,
  output logic [15:0]      frames_captured,
  output logic [7:0]       sof_errors
);

  typedef enum logic [1:0] {
    IDLE, ARMED, CAPT, DONE
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_e           state_q;
  logic [AW-1:0]    addr_q;
  logic             pending_q;
  logic             front_q;
  logic             fv_q;
  logic             cmpl_q;
  logic [15:0]      frames_q;
  logic [7:0]       serr_q;
  logic             rvalid_q;
  logic             rin_q;
  logic [PIX_W-1:0] ram_q;

  logic [PIX_W-1:0] mem [0:1][0:N-1];

  logic             active;
  logic             hs;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PIX_W-1:0] pix;
  logic             rd_in;
  logic [AW-1:0]    rd_idx;

  assign active  = (state_q == ARMED) || (state_q == CAPT);
  assign hs      = x_valid && active && !capture_abort;
  assign wr_en   = hs && (x_sof || state_q == CAPT);
  assign wr_addr = x_sof ? '0 : addr_q;
  assign pix     = thresh_mode ? {PIX_W{x_data >= threshold}}
                               : x_data[IN_W-1 -: PIX_W];
  assign rd_in   = 32'(rd_addr) < 32'(N);
  assign rd_idx  = rd_in ? rd_addr : '0;

  // RAM has no reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (wr_en) mem[~front_q][wr_addr] <= pix;
    if (rd_en) ram_q <= mem[front_q][rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pending_q <= 1'b0;
      front_q   <= 1'b0;
      fv_q      <= 1'b0;
      cmpl_q    <= 1'b0;
      frames_q  <= '0;
      serr_q    <= '0;
      rvalid_q  <= 1'b0;
      rin_q     <= 1'b0;
    end else begin
      cmpl_q   <= 1'b0;
      rvalid_q <= rd_en;
      rin_q    <= rd_in;
      if (pending_q && !rd_hold) begin
        front_q   <= ~front_q;
        fv_q      <= 1'b1;
        pending_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (!pending_q && (capture_trigger || continuous))
            state_q <= ARMED;
        end
        ARMED, CAPT: begin
          if (capture_abort) begin
            state_q <= IDLE;
            addr_q  <= '0;
          end else if (hs && x_sof) begin
            addr_q  <= AW'(1);
            state_q <= CAPT;
            if (state_q == CAPT && serr_q != 8'hFF)
              serr_q <= serr_q + 8'd1;
          end else if (hs && state_q == CAPT) begin
            if (addr_q == LAST) begin
              state_q  <= DONE;
              addr_q   <= '0;
              cmpl_q   <= 1'b1;
              frames_q <= frames_q + 16'd1;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        DONE: begin
          if (rd_hold) begin
            pending_q <= 1'b1;
          end else begin
            front_q <= ~front_q;
            fv_q    <= 1'b1;
          end
          state_q <= (continuous && !rd_hold) ? ARMED : IDLE;
        end
      endcase
    end
  end

  assign x_ready          = active;
  assign capturing        = active;
  assign capture_complete = cmpl_q;
  assign frame_valid      = fv_q;
  assign front_bank       = front_q;
  assign frames_captured  = frames_q;
  assign sof_errors       = serr_q;
  assign rd_valid         = rvalid_q;
  assign rd_data          = (rvalid_q && rin_q) ? ram_q : '0;

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Bench for frame_capture_buffer: 4x2 frames, PIX_W=1 and PIX_W=4
// instances driven in lockstep, read data checked through queues.
module tb_frame_capture_buffer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          x_valid = 1'b0;
  logic [7:0]    x_data = '0;
  logic          x_sof = 1'b0;
  logic          capture_trigger = 1'b0;
  logic          continuous = 1'b0;
  logic          capture_abort = 1'b0;
  logic          thresh_mode = 1'b0;
  logic [7:0]    threshold = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_hold = 1'b0;

  logic          x_ready, rd_valid, capturing, capture_complete;
  logic          frame_valid, front_bank;
  logic [0:0]    rd_data;
  logic [15:0]   frames_captured;
  logic [7:0]    sof_errors;

  logic          x_ready4, rd_valid4, capturing4, capture_complete4;
  logic          frame_valid4, front_bank4;
  logic [3:0]    rd_data4;
  logic [15:0]   frames_captured4;
  logic [7:0]    sof_errors4;

  always #5 clk = ~clk;

  frame_capture_buffer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .IN_W(8), .PIX_W(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .x_sof(x_sof), .capture_trigger(capture_trigger),
    .continuous(continuous), .capture_abort(capture_abort),
    .thresh_mode(thresh_mode), .threshold(threshold), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_hold(rd_hold), .rd_data(rd_data),
    .rd_valid(rd_valid), .capturing(capturing),
    .capture_complete(capture_complete), .frame_valid(frame_valid),
    .front_bank(front_bank), .frames_captured(frames_captured),
    .sof_errors(sof_errors)
  );

  frame_capture_buffer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .IN_W(8), .PIX_W(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready4),
    .x_data(x_data), .x_sof(x_sof), .capture_trigger(capture_trigger),
    .continuous(continuous), .capture_abort(capture_abort),
    .thresh_mode(thresh_mode), .threshold(threshold), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_hold(rd_hold), .rd_data(rd_data4),
    .rd_valid(rd_valid4), .capturing(capturing4),
    .capture_complete(capture_complete4), .frame_valid(frame_valid4),
    .front_bank(front_bank4), .frames_captured(frames_captured4),
    .sof_errors(sof_errors4)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         ncomp = 0;
  logic [3:0] q1[$];
  logic [3:0] q4[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (capture_complete) ncomp++;
      if (rd_valid) begin
        if (q1.size() == 0) chk("rd1_extra", 32'(rd_valid), 0);
        else chk("rd1_data", 32'(rd_data), 32'(q1.pop_front()));
      end
      if (rd_valid4) begin
        if (q4.size() == 0) chk("rd4_extra", 32'(rd_valid4), 0);
        else chk("rd4_data", 32'(rd_data4), 32'(q4.pop_front()));
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int k;
    x_valid = 1'b1;
    x_data  = d;
    x_sof   = s;
    k = 0;
    while (!x_ready && k < 20) begin
      cyc(1);
      k++;
    end
    if (k == 20) chk("x_ready_wait", 32'(x_ready), 1);
    cyc(1);
    x_valid = 1'b0;
    x_sof   = 1'b0;
  endtask

  task automatic rd(input int a, input logic [3:0] e1, input logic [3:0] e4);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    q1.push_back(e1);
    q4.push_back(e4);
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    cyc(1);
    chk("rd1_pending", 32'(q1.size()), 0);
    chk("rd4_pending", 32'(q4.size()), 0);
  endtask

  task automatic trig();
    capture_trigger = 1'b1;
    cyc(1);
    capture_trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int   c0;
    tv[0] = '{8'd0,   1'b1, 1'b0};
    tv[1] = '{8'd255, 1'b0, 1'b1};
    tv[2] = '{8'd127, 1'b0, 1'b0};
    tv[3] = '{8'd128, 1'b0, 1'b1};
    tv[4] = '{8'd200, 1'b0, 1'b1};
    tv[5] = '{8'd0,   1'b0, 1'b0};
    tv[6] = '{8'd255, 1'b0, 1'b1};
    tv[7] = '{8'd1,   1'b0, 1'b0};

    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_x_ready", 32'(x_ready), 0);
    chk("rst_capturing", 32'(capturing), 0);
    chk("rst_front", 32'(front_bank), 0);
    chk("rst_fvalid", 32'(frame_valid), 0);
    chk("rst_frames", 32'(frames_captured), 0);
    chk("rst_serr", 32'(sof_errors), 0);
    chk("rst_rvalid", 32'(rd_valid), 0);
    chk("rst_capturing4", 32'(capturing4), 0);

    // binary capture
    thresh_mode = 1'b1;
    threshold   = 8'd128;
    trig();
    chk("armed", 32'(capturing), 1);
    for (int i = 0; i < 8; i++) send(tv[i].d, tv[i].s);
    chk("bin_complete", 32'(capture_complete), 1);
    chk("bin_front_pre", 32'(front_bank), 0);
    cyc(1);
    chk("bin_complete_end", 32'(capture_complete), 0);
    chk("bin_front", 32'(front_bank), 1);
    chk("bin_fvalid", 32'(frame_valid), 1);
    chk("bin_fvalid4", 32'(frame_valid4), 1);
    chk("bin_frames", 32'(frames_captured), 1);
    chk("bin_ncomp", 32'(ncomp), 1);
    for (int i = 0; i < 8; i++) rd(i, {3'b0, tv[i].e}, {4{tv[i].e}});
    drain();

    // SOF alignment
    trig();
    for (int i = 0; i < 3; i++) send(8'd255, 1'b0);
    chk("align_armed", 32'(capturing), 1);
    send(8'd200, 1'b1);
    for (int i = 1; i < 8; i++) send(8'd0, 1'b0);
    chk("align_complete", 32'(capture_complete), 1);
    cyc(1);
    chk("align_front", 32'(front_bank), 0);
    chk("align_frames", 32'(frames_captured), 2);
    chk("align_serr", 32'(sof_errors), 0);
    for (int i = 0; i < 8; i++)
      rd(i, (i == 0) ? 4'h1 : 4'h0, (i == 0) ? 4'hF : 4'h0);
    drain();

    // early SOF
    trig();
    send(8'd0, 1'b1);
    for (int i = 1; i < 5; i++) send(8'd255, 1'b0);
    send(8'd200, 1'b1);
    chk("esof_serr", 32'(sof_errors), 1);
    chk("esof_serr4", 32'(sof_errors4), 1);
    c0 = ncomp;
    for (int j = 1; j < 7; j++) send((j % 2 == 0) ? 8'd255 : 8'd0, 1'b0);
    chk("esof_not_done", 32'(ncomp - c0), 0);
    chk("esof_still_cap", 32'(capturing), 1);
    send(8'd0, 1'b0);
    chk("esof_complete", 32'(capture_complete), 1);
    cyc(1);
    chk("esof_front", 32'(front_bank), 1);
    chk("esof_frames", 32'(frames_captured), 3);
    for (int i = 0; i < 8; i++)
      rd(i, (i % 2 == 0) ? 4'h1 : 4'h0, (i % 2 == 0) ? 4'hF : 4'h0);
    drain();

    // hold deferral
    rd_hold = 1'b1;
    trig();
    send(8'd0, 1'b1);
    for (int i = 1; i < 8; i++) send(8'd255, 1'b0);
    cyc(1);
    chk("hold_front", 32'(front_bank), 1);
    trig();
    chk("hold_trig_ignored", 32'(capturing), 0);
    rd(0, 4'h1, 4'hF);
    rd(1, 4'h0, 4'h0);
    cyc(6);
    chk("hold_front_late", 32'(front_bank), 1);
    chk("hold_frames", 32'(frames_captured), 4);
    rd_hold = 1'b0;
    chk("hold_front_rel", 32'(front_bank), 1);
    cyc(1);
    chk("hold_swapped", 32'(front_bank), 0);
    chk("hold_fvalid", 32'(frame_valid), 1);
    chk("hold_idle", 32'(capturing), 0);
    for (int i = 0; i < 8; i++)
      rd(i, (i == 0) ? 4'h0 : 4'h1, (i == 0) ? 4'h0 : 4'hF);
    drain();

    // continuous raw mode
    c0 = ncomp;
    thresh_mode = 1'b0;
    continuous  = 1'b1;
    cyc(1);
    for (int f = 0; f < 3; f++) begin
      send(8'hA7, 1'b1);
      for (int i = 1; i < 8; i++) send(8'hA7, 1'b0);
    end
    continuous = 1'b0;
    cyc(1);
    chk("cont_ncomp", 32'(ncomp - c0), 3);
    chk("cont_front", 32'(front_bank), 1);
    chk("cont_front4", 32'(front_bank4), 1);
    chk("cont_frames", 32'(frames_captured), 7);
    chk("cont_frames4", 32'(frames_captured4), 7);
    chk("cont_idle", 32'(capturing), 0);
    rd(0, 4'h1, 4'hA);
    rd(7, 4'h1, 4'hA);
    drain();

    // abort then reset mid-capture
    c0 = ncomp;
    trig();
    send(8'd0, 1'b1);
    for (int i = 1; i < 4; i++) send(8'd0, 1'b0);
    x_valid       = 1'b1;
    capture_abort = 1'b1;
    cyc(1);
    x_valid       = 1'b0;
    capture_abort = 1'b0;
    chk("abort_cap", 32'(capturing), 0);
    chk("abort_ready", 32'(x_ready), 0);
    chk("abort_frames", 32'(frames_captured), 7);
    chk("abort_front", 32'(front_bank), 1);
    cyc(2);
    chk("abort_ncomp", 32'(ncomp - c0), 0);
    trig();
    send(8'd0, 1'b1);
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cap", 32'(capturing), 0);
    chk("mrst_ready", 32'(x_ready4), 0);
    chk("mrst_front", 32'(front_bank), 0);
    chk("mrst_fvalid", 32'(frame_valid), 0);
    chk("mrst_frames", 32'(frames_captured), 0);
    chk("mrst_serr", 32'(sof_errors), 0);
    chk("mrst_cmpl", 32'(capture_complete4), 0);
    chk("mrst_rdata4", 32'(rd_data4), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    chk("mrst_ncomp", 32'(ncomp - c0), 0);
    chk("mrst_fvalid_after", 32'(frame_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
